// File: rtl/codec_intf_if.sv
// Parallel sample interface between the codec serial port and the filter bank.
// The codec side (master) produces ADC words and vld; the filter side returns DAC words.
interface codec_intf_if #(
    parameter int DW = 16
);
    logic signed [DW-1:0] lft_in;
    logic signed [DW-1:0] rht_in;
    logic                 vld;
    logic signed [DW-1:0] lft_out;
    logic signed [DW-1:0] rht_out;

    modport master (
        output lft_in,
        output rht_in,
        output vld,
        input  lft_out,
        input  rht_out
    );

    modport slave (
        input  lft_in,
        input  rht_in,
        input  vld,
        output lft_out,
        output rht_out
    );
endinterface

// File: rtl/codec_intf.sv
// CS4272 serial audio port: clock generation, codec reset hold, I2S receive/transmit.
// One 11-bit counter defines the whole frame; every serial event is decoded from it.
module codec_intf #(
    parameter int DW         = 16,
    parameter int RST_FRAMES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         MCLK,
    output logic         SCLK,
    output logic         LRCLK,
    output logic         RSTn,
    input  logic         SDout,
    output logic         SDin,
    codec_intf_if.master dp
);

    localparam int             FW        = (RST_FRAMES > 1) ? $clog2(RST_FRAMES) : 1;
    localparam logic [FW-1:0]  FRM_LAST  = FW'(RST_FRAMES - 1);
    localparam logic [4:0]     LAST_SLOT = 5'(DW);

    logic [10:0]   cnt_reg;
    logic [FW-1:0] frm_reg;
    logic [FW-1:0] frm_next;
    logic          rstn_reg;
    logic          rstn_next;
    logic [DW-1:0] rx_reg;
    logic [DW-1:0] rx_next;
    logic [DW-1:0] tx_reg;
    logic [DW-1:0] tx_next;
    logic          sdin_reg;
    logic          sdin_next;
    logic          vld_reg;
    logic          vld_next;
    logic [DW-1:0] in_reg  [2];
    logic [DW-1:0] buf_reg [2];
    logic [DW-1:0] out_word[2];

    logic [4:0]    slot;
    logic          half;
    logic          sclk_rise;
    logic          sclk_fall;
    logic          rx_slot;
    logic          cap_evt;
    logic [DW-1:0] rx_word;

    assign slot      = cnt_reg[9:5];
    assign half      = cnt_reg[10];
    assign sclk_rise = (cnt_reg[4:0] == 5'h0F);
    assign sclk_fall = (cnt_reg[4:0] == 5'h1F);
    assign rx_slot   = (slot != 5'd0) && (slot <= LAST_SLOT);
    assign cap_evt   = sclk_rise && (slot == LAST_SLOT);
    assign rx_word   = (rx_reg << 1) | DW'(SDout);

    assign out_word[0] = dp.lft_out;
    assign out_word[1] = dp.rht_out;

    // Clock pins come straight from counter flops so they cannot glitch.
    assign MCLK      = cnt_reg[1];
    assign SCLK      = cnt_reg[4];
    assign LRCLK     = cnt_reg[10];
    assign RSTn      = rstn_reg;
    assign SDin      = sdin_reg;
    assign dp.vld    = vld_reg;
    assign dp.lft_in = in_reg[0];
    assign dp.rht_in = in_reg[1];

    always_comb begin
        frm_next  = frm_reg;
        rstn_next = rstn_reg;
        rx_next   = rx_reg;
        tx_next   = tx_reg;
        sdin_next = sdin_reg;
        vld_next  = cap_evt && half && rstn_reg;

        if ((cnt_reg == 11'h7FF) && !rstn_reg) begin
            if (frm_reg == FRM_LAST) begin
                rstn_next = 1'b1;
            end else begin
                frm_next = frm_reg + 1'b1;
            end
        end

        if (sclk_rise && rx_slot) begin
            rx_next = rx_word;
        end

        // Data changes on SCLK fall so the codec sees it stable on the next rise.
        if (sclk_fall) begin
            if (slot == 5'd0) begin
                tx_next   = half ? buf_reg[1] : buf_reg[0];
                sdin_next = tx_next[DW-1];
            end else if (slot < LAST_SLOT) begin
                tx_next   = tx_reg << 1;
                sdin_next = tx_next[DW-1];
            end else begin
                sdin_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            frm_reg  <= '0;
            rstn_reg <= 1'b0;
            rx_reg   <= '0;
            tx_reg   <= '0;
            sdin_reg <= 1'b0;
            vld_reg  <= 1'b0;
        end else begin
            cnt_reg  <= cnt_reg + 11'd1;
            frm_reg  <= frm_next;
            rstn_reg <= rstn_next;
            rx_reg   <= rx_next;
            tx_reg   <= tx_next;
            sdin_reg <= sdin_next;
            vld_reg  <= vld_next;
        end
    end

    // Buffers load on vld, which lands after the right word has been latched into tx_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                in_reg[ch]  <= '0;
                buf_reg[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (cap_evt && (half == (ch == 1))) begin
                    in_reg[ch] <= rx_word;
                end
                if (vld_reg) begin
                    buf_reg[ch] <= out_word[ch];
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_intf.sv
// Bench for codec_intf: a timeline-based codec model drives SDout and decodes SDin,
// a frame table holds the words sent each way, and every output is checked per cycle.
`timescale 1ns/1ps
module tb_codec_intf;

    logic clk;
    logic rst_n;
    logic MCLK, SCLK, LRCLK, RSTn, SDout, SDin;

    codec_intf_if #(.DW(16)) dp ();

    codec_intf #(.DW(16), .RST_FRAMES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .MCLK  (MCLK),
        .SCLK  (SCLK),
        .LRCLK (LRCLK),
        .RSTn  (RSTn),
        .SDout (SDout),
        .SDin  (SDin),
        .dp    (dp.master)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int t        = 0;

    logic [15:0] rx_w   [2][32];
    logic [15:0] tx_w   [2][32];
    bit          loop_f [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [15:0] exp_tx(input int f, input int h);
        return (f >= 2) ? tx_w[h][f-1] : 16'h0000;
    endfunction

    // Codec model and scoreboard, timed purely by clocks elapsed since reset release.
    int          c, f, h, s, b;
    logic [15:0] acc;
    bit          zbad;
    bit          vexp;

    always begin
        @(posedge clk);
        if (rst_n) t++;
        #1;
        if (!rst_n) begin
            acc  = '0;
            zbad = 1'b0;
        end else begin
            c = t % 2048;
            f = t / 2048;
            h = c / 1024;
            s = (c % 1024) / 32;
            b = c % 32;
            chk("clocks", {29'd0, MCLK, SCLK, LRCLK}, {29'd0, c[1], c[4], c[10]});
            chk("rstn", {31'd0, RSTn}, {31'd0, (t >= 2048)});
            vexp = (c == 32'h610) && (t >= 2048);
            if (dp.vld || vexp) chk("vld", {31'd0, dp.vld}, {31'd0, vexp});
            if (vexp) begin
                chk("lft_in", {16'd0, dp.lft_in}, {16'd0, rx_w[0][f]});
                chk("rht_in", {16'd0, dp.rht_in}, {16'd0, rx_w[1][f]});
                $display("frame %0d: vld lft_in=%h rht_in=%h", f, dp.lft_in, dp.rht_in);
                if (loop_f[f]) begin
                    dp.lft_out = dp.lft_in;
                    dp.rht_out = dp.rht_in;
                end
            end
            if ((c == 32'h100) && !loop_f[f]) begin
                dp.lft_out = tx_w[0][f];
                dp.rht_out = tx_w[1][f];
            end
            if (b == 0) begin
                SDout = (s >= 1 && s <= 16) ? rx_w[h][f][16-s] : 1'b0;
            end
            if (b == 16) begin
                if (s >= 1 && s <= 16) begin
                    acc = {acc[14:0], SDin};
                    if (s == 16) begin
                        chk(h ? "sdin_rht" : "sdin_lft", {16'd0, acc}, {16'd0, exp_tx(f, h)});
                        $display("frame %0d half %0d: SDin word %h", f, h, acc);
                    end
                end else begin
                    if (SDin !== 1'b0) zbad = 1'b1;
                    if (s == 31) begin
                        chk("sdin_idle_zero", {31'd0, zbad}, 32'd0);
                        zbad = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_t(input int target);
        while (t < target) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_clks"},  {29'd0, MCLK, SCLK, LRCLK}, 32'd0);
        chk({tag, "_sdin"},  {31'd0, SDin}, 32'd0);
        chk({tag, "_vld"},   {31'd0, dp.vld}, 32'd0);
        chk({tag, "_rstn"},  {31'd0, RSTn}, 32'd0);
        chk({tag, "_lft"},   {16'd0, dp.lft_in}, 32'd0);
        chk({tag, "_rht"},   {16'd0, dp.rht_in}, 32'd0);
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            rx_w[0][k] = 16'($urandom);
            rx_w[1][k] = 16'($urandom);
            tx_w[0][k] = 16'($urandom);
            tx_w[1][k] = 16'($urandom);
            loop_f[k]  = 1'b0;
        end
    endtask

    real ph;

    initial begin
        rst_n      = 1'b0;
        SDout      = 1'b0;
        dp.lft_out = '0;
        dp.rht_out = '0;
        t          = 0;

        // Epoch 1 frame table: directed words, full-scale, random, then sine loopback.
        fill_random(0, 31);
        rx_w[0][1] = 16'h1234; rx_w[1][1] = 16'hA5C3;
        tx_w[0][1] = 16'h8001; tx_w[1][1] = 16'h7FFE;
        rx_w[0][2] = 16'h8000; rx_w[1][2] = 16'h7FFF;
        tx_w[0][2] = 16'h8000; tx_w[1][2] = 16'h7FFF;
        for (int k = 11; k <= 23; k++) begin
            ph = 2.0 * 3.14159265358979 * 1000.0 * real'(k) / 24414.0;
            rx_w[0][k] = 16'($rtoi(32000.0 * $sin(ph)));
            rx_w[1][k] = 16'($rtoi(32000.0 * $cos(ph)));
            tx_w[0][k] = rx_w[0][k];
            tx_w[1][k] = rx_w[1][k];
            loop_f[k]  = 1'b1;
        end

        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        $display("reset state checked");
        rst_n = 1'b1;

        wait_t(23 * 2048 + 32'h305);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        $display("mid-frame reset at cnt=305 checked");
        t = 0;
        fill_random(0, 31);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;

        wait_t(4 * 2048 + 100);
        chk("vld_after_run", {31'd0, dp.vld}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
